// File: rtl/mc_control_fsm.sv
// mc_control_fsm
//   Multicycle control sequencer for the MIPS-subset datapath. Walks each
//   instruction through FETCH / DECODE / EXEC / MEM / WB states, stretches
//   memory accesses by MEM_WAIT cycles, holds MULT/DIV for MD_CYCLES cycles,
//   and raises precise exceptions (EPC write + cause code).
//   All control outputs are registered: each one is decoded from the next
//   state/counter at the clock edge, so it is glitch-free for the whole
//   cycle in which state_out shows that state.
// Ports
//   clk, reset (async, active-low)
//   opcode, funct           instruction fields, stable from DECODE onward
//   zero                    ALU zero flag (gated by the datapath branch logic)
//   overflow, div_zero      exception sources, sampled only when leaving
//                           EXEC_R / EXEC_I / the first MD_RUN cycle
//   pc_write .. alu_op      datapath mux selects and write enables
//   cause                   last exception cause, held until the next one
//   state_out               current state code
module mc_control_fsm #(
  parameter int MEM_WAIT  = 1,
  parameter int MD_CYCLES = 32,
  parameter int CNT_W     = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       overflow,
  input  logic       div_zero,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       branch_ne,
  output logic [1:0] pc_source,
  output logic       exc_vec_sel,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       epc_write,
  output logic       md_start,
  output logic       md_op,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       hilo_sel,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [3:0] alu_op,
  output logic [1:0] cause,
  output logic [3:0] state_out
);

  typedef enum logic [3:0] {
    S_RESET = 4'd0, S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I,
    S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP, S_MD_RUN,
    S_MFHL, S_EXC
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic [1:0] pc_source;
    logic       exc_vec_sel;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       epc_write;
    logic       md_start;
    logic       md_op;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       hilo_sel;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
  } ctl_t;

  localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SUB = 4'b0001,
                         ALU_AND = 4'b0010, ALU_SLT = 4'b0011,
                         ALU_LUI = 4'b0100;

  localparam logic [1:0] CAUSE_OP = 2'b00, CAUSE_OVF = 2'b01, CAUSE_DIV = 2'b10;

  localparam logic [CNT_W-1:0] LIM_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] LIM_MEM = CNT_W'(MEM_WAIT);
  localparam logic [CNT_W-1:0] LIM_MD  = CNT_W'(MD_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, lim;
  logic [1:0]       cause_q, cause_d;
  ctl_t             ctl_q, ctl_d;
  logic             cnt_done;

  // The branch decision (zero ^ branch_ne) is resolved in the datapath PC
  // gate, so the flag is only carried on this port for interface symmetry.
  logic unused_zero;
  assign unused_zero = zero;

  // Instruction classification
  logic is_r, f_add, f_sub, f_and, f_slt, f_mult, f_div, f_mfhi, f_mflo, f_jr;
  logic op_addi, op_lui, op_lw, op_sw, op_beq, op_bne, op_j, op_jal;
  logic r_alu, r_ovf, r_md, r_mfhl, r_jr, i_div;

  always_comb begin
    is_r    = (opcode == 6'b000000);
    f_add   = (funct == 6'b100000);
    f_sub   = (funct == 6'b100010);
    f_and   = (funct == 6'b100100);
    f_slt   = (funct == 6'b101010);
    f_mult  = (funct == 6'b011000);
    f_div   = (funct == 6'b011010);
    f_mfhi  = (funct == 6'b010000);
    f_mflo  = (funct == 6'b010010);
    f_jr    = (funct == 6'b001000);
    op_addi = (opcode == 6'b001000);
    op_lui  = (opcode == 6'b001111);
    op_lw   = (opcode == 6'b100011);
    op_sw   = (opcode == 6'b101011);
    op_beq  = (opcode == 6'b000100);
    op_bne  = (opcode == 6'b000101);
    op_j    = (opcode == 6'b000010);
    op_jal  = (opcode == 6'b000011);
    r_alu   = is_r & (f_add | f_sub | f_and | f_slt);
    r_ovf   = is_r & (f_add | f_sub);
    r_md    = is_r & (f_mult | f_div);
    r_mfhl  = is_r & (f_mfhi | f_mflo);
    r_jr    = is_r & f_jr;
    i_div   = is_r & f_div;
  end

  // Exit limit of the current counted state. RESET holds two edges so the
  // first FETCH is well clear of reset release; MEM_ADDR holds two so the
  // address is settled in ALUOut before the memory sees it.
  always_comb begin
    case (state_q)
      S_RESET, S_MEM_ADDR:          lim = LIM_ONE;
      S_FETCH, S_MEM_RD, S_MEM_WR:  lim = LIM_MEM;
      S_MD_RUN:                     lim = LIM_MD;
      default:                      lim = '0;
    endcase
    cnt_done = (cnt_q == lim);
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      S_RESET:  if (cnt_done) state_d = S_FETCH;
      S_FETCH:  if (cnt_done) state_d = S_DECODE;
      S_DECODE: begin
        if (r_alu)                      state_d = S_EXEC_R;
        else if (r_md)                  state_d = S_MD_RUN;
        else if (r_mfhl)                state_d = S_MFHL;
        else if (r_jr | op_j | op_jal)  state_d = S_JUMP;
        else if (op_addi | op_lui)      state_d = S_EXEC_I;
        else if (op_lw | op_sw)         state_d = S_MEM_ADDR;
        else if (op_beq | op_bne)       state_d = S_BRANCH;
        else begin
          state_d = S_EXC;
          cause_d = CAUSE_OP;
        end
      end
      S_EXEC_R: begin
        if (r_ovf && overflow) begin
          state_d = S_EXC;
          cause_d = CAUSE_OVF;
        end else begin
          state_d = S_WB_R;
        end
      end
      S_EXEC_I: begin
        if (op_addi && overflow) begin
          state_d = S_EXC;
          cause_d = CAUSE_OVF;
        end else begin
          state_d = S_WB_I;
        end
      end
      S_MEM_ADDR: if (cnt_done) state_d = op_lw ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (cnt_done) state_d = S_MEM_WB;
      S_MEM_WR:   if (cnt_done) state_d = S_FETCH;
      S_MD_RUN: begin
        // Divide-by-zero is only meaningful at the start pulse.
        if (cnt_q == '0 && i_div && div_zero) begin
          state_d = S_EXC;
          cause_d = CAUSE_DIV;
        end else if (cnt_done) begin
          state_d = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
    cnt_d = (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);
  end

  // Outputs for the cycle about to begin, decoded from the next state.
  always_comb begin
    ctl_d = '0;
    case (state_d)
      S_FETCH: begin
        ctl_d.mem_read  = 1'b1;
        ctl_d.alu_src_b = 2'b01;
        ctl_d.alu_op    = ALU_ADD;
        if (cnt_d == LIM_MEM) begin
          ctl_d.ir_write = 1'b1;
          ctl_d.pc_write = 1'b1;
        end
      end
      S_DECODE: ctl_d.alu_src_b = 2'b11;
      S_EXEC_R: begin
        ctl_d.alu_src_a = 1'b1;
        ctl_d.alu_src_b = 2'b00;
        if (f_sub)      ctl_d.alu_op = ALU_SUB;
        else if (f_and) ctl_d.alu_op = ALU_AND;
        else if (f_slt) ctl_d.alu_op = ALU_SLT;
        else            ctl_d.alu_op = ALU_ADD;
      end
      S_WB_R: begin
        ctl_d.reg_dst   = 2'b01;
        ctl_d.reg_write = 1'b1;
      end
      S_EXEC_I: begin
        ctl_d.alu_src_a = 1'b1;
        ctl_d.alu_src_b = 2'b10;
        ctl_d.alu_op    = op_lui ? ALU_LUI : ALU_ADD;
      end
      S_WB_I: ctl_d.reg_write = 1'b1;
      S_MEM_ADDR: begin
        ctl_d.alu_src_a = 1'b1;
        ctl_d.alu_src_b = 2'b10;
        ctl_d.alu_op    = ALU_ADD;
      end
      S_MEM_RD: ctl_d.mem_read  = 1'b1;
      S_MEM_WR: ctl_d.mem_write = 1'b1;
      S_MEM_WB: begin
        ctl_d.mem_to_reg = 2'b01;
        ctl_d.reg_write  = 1'b1;
      end
      S_BRANCH: begin
        ctl_d.alu_src_a     = 1'b1;
        ctl_d.alu_src_b     = 2'b00;
        ctl_d.alu_op        = ALU_SUB;
        ctl_d.pc_write_cond = 1'b1;
        ctl_d.pc_source     = 2'b01;
        ctl_d.branch_ne     = op_bne;
      end
      S_JUMP: begin
        ctl_d.pc_write  = 1'b1;
        ctl_d.pc_source = r_jr ? 2'b11 : 2'b10;
        if (op_jal) begin
          ctl_d.reg_write  = 1'b1;
          ctl_d.reg_dst    = 2'b10;
          ctl_d.mem_to_reg = 2'b10;
        end
      end
      S_MD_RUN: begin
        if (cnt_d == '0) begin
          ctl_d.md_start = 1'b1;
          ctl_d.md_op    = i_div;
        end
      end
      S_MFHL: begin
        ctl_d.reg_dst    = 2'b01;
        ctl_d.mem_to_reg = 2'b11;
        ctl_d.hilo_sel   = f_mfhi;
        ctl_d.reg_write  = 1'b1;
      end
      S_EXC: begin
        ctl_d.epc_write   = 1'b1;
        ctl_d.pc_write    = 1'b1;
        ctl_d.exc_vec_sel = 1'b1;
      end
      default: ctl_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_RESET;
      cnt_q   <= '0;
      cause_q <= CAUSE_OP;
      ctl_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
      ctl_q   <= ctl_d;
    end
  end

  assign pc_write      = ctl_q.pc_write;
  assign pc_write_cond = ctl_q.pc_write_cond;
  assign branch_ne     = ctl_q.branch_ne;
  assign pc_source     = ctl_q.pc_source;
  assign exc_vec_sel   = ctl_q.exc_vec_sel;
  assign ir_write      = ctl_q.ir_write;
  assign mem_read      = ctl_q.mem_read;
  assign mem_write     = ctl_q.mem_write;
  assign reg_write     = ctl_q.reg_write;
  assign epc_write     = ctl_q.epc_write;
  assign md_start      = ctl_q.md_start;
  assign md_op         = ctl_q.md_op;
  assign reg_dst       = ctl_q.reg_dst;
  assign mem_to_reg    = ctl_q.mem_to_reg;
  assign hilo_sel      = ctl_q.hilo_sel;
  assign alu_src_a     = ctl_q.alu_src_a;
  assign alu_src_b     = ctl_q.alu_src_b;
  assign alu_op        = ctl_q.alu_op;
  assign cause         = cause_q;
  assign state_out     = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm. Instance A: MEM_WAIT=1, MD_CYCLES=4.
// Instance B: MEM_WAIT=3 (lw timing). Expected per-cycle state, write
// enables and selected mux fields are queued as stimulus is applied and
// popped/compared one clock later each cycle.
module tb_mc_control_fsm;

  typedef struct packed {
    logic       bne;
    logic [1:0] pcs;
    logic [1:0] rdst;
    logic [1:0] m2r;
    logic       hl;
    logic       mdop;
    logic [1:0] cause;
    logic [3:0] aluop;
    logic       srca;
    logic [1:0] srcb;
  } sel_t;

  typedef struct packed {
    logic [3:0] st;
    logic [8:0] we;
    sel_t       s;
    sel_t       m;
  } exp_t;

  // write-enable vector bits {pc_write, pc_write_cond, ir_write, mem_read,
  // mem_write, reg_write, epc_write, md_start, exc_vec_sel}
  localparam logic [8:0] PCW = 9'h100, PCC = 9'h080, IRW = 9'h040,
                         MRD = 9'h020, MWR = 9'h010, RGW = 9'h008,
                         EPC = 9'h004, MDS = 9'h002, EXV = 9'h001;
  localparam logic [8:0] EXCW = PCW | EPC | EXV;

  localparam logic [3:0] RESET = 4'd0, FETCH = 4'd1, DECODE = 4'd2,
    EXEC_R = 4'd3, WB_R = 4'd4, MEM_ADDR = 4'd7, MEM_RD = 4'd8,
    MEM_WB = 4'd9, BRANCH = 4'd11, JUMP = 4'd12, MD_RUN = 4'd13,
    MFHL = 4'd14, EXC = 4'd15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A stimulus and outputs
  logic       reset_a, zero_a, ovf_a, dz_a;
  logic [5:0] opcode_a, funct_a;
  logic       pc_write_a, pc_write_cond_a, branch_ne_a, exc_vec_sel_a, ir_write_a;
  logic       mem_read_a, mem_write_a, reg_write_a, epc_write_a, md_start_a, md_op_a;
  logic       hilo_sel_a, alu_src_a_a;
  logic [1:0] pc_source_a, reg_dst_a, mem_to_reg_a, alu_src_b_a, cause_a;
  logic [3:0] alu_op_a, state_a;

  // Instance B stimulus and outputs
  logic       reset_b, zero_b, ovf_b, dz_b;
  logic [5:0] opcode_b, funct_b;
  logic       pc_write_b, pc_write_cond_b, branch_ne_b, exc_vec_sel_b, ir_write_b;
  logic       mem_read_b, mem_write_b, reg_write_b, epc_write_b, md_start_b, md_op_b;
  logic       hilo_sel_b, alu_src_a_b;
  logic [1:0] pc_source_b, reg_dst_b, mem_to_reg_b, alu_src_b_b, cause_b;
  logic [3:0] alu_op_b, state_b;

  mc_control_fsm #(.MEM_WAIT(1), .MD_CYCLES(4), .CNT_W(6)) u_dut_a (
    .clk(clk), .reset(reset_a), .opcode(opcode_a), .funct(funct_a),
    .zero(zero_a), .overflow(ovf_a), .div_zero(dz_a),
    .pc_write(pc_write_a), .pc_write_cond(pc_write_cond_a),
    .branch_ne(branch_ne_a), .pc_source(pc_source_a),
    .exc_vec_sel(exc_vec_sel_a), .ir_write(ir_write_a),
    .mem_read(mem_read_a), .mem_write(mem_write_a), .reg_write(reg_write_a),
    .epc_write(epc_write_a), .md_start(md_start_a), .md_op(md_op_a),
    .reg_dst(reg_dst_a), .mem_to_reg(mem_to_reg_a), .hilo_sel(hilo_sel_a),
    .alu_src_a(alu_src_a_a), .alu_src_b(alu_src_b_a), .alu_op(alu_op_a),
    .cause(cause_a), .state_out(state_a));

  mc_control_fsm #(.MEM_WAIT(3), .MD_CYCLES(4), .CNT_W(6)) u_dut_b (
    .clk(clk), .reset(reset_b), .opcode(opcode_b), .funct(funct_b),
    .zero(zero_b), .overflow(ovf_b), .div_zero(dz_b),
    .pc_write(pc_write_b), .pc_write_cond(pc_write_cond_b),
    .branch_ne(branch_ne_b), .pc_source(pc_source_b),
    .exc_vec_sel(exc_vec_sel_b), .ir_write(ir_write_b),
    .mem_read(mem_read_b), .mem_write(mem_write_b), .reg_write(reg_write_b),
    .epc_write(epc_write_b), .md_start(md_start_b), .md_op(md_op_b),
    .reg_dst(reg_dst_b), .mem_to_reg(mem_to_reg_b), .hilo_sel(hilo_sel_b),
    .alu_src_a(alu_src_a_b), .alu_src_b(alu_src_b_b), .alu_op(alu_op_b),
    .cause(cause_b), .state_out(state_b));

  logic [8:0] we_a, we_b;
  sel_t       sel_a, sel_b;
  assign we_a  = {pc_write_a, pc_write_cond_a, ir_write_a, mem_read_a, mem_write_a,
                  reg_write_a, epc_write_a, md_start_a, exc_vec_sel_a};
  assign we_b  = {pc_write_b, pc_write_cond_b, ir_write_b, mem_read_b, mem_write_b,
                  reg_write_b, epc_write_b, md_start_b, exc_vec_sel_b};
  assign sel_a = {branch_ne_a, pc_source_a, reg_dst_a, mem_to_reg_a, hilo_sel_a,
                  md_op_a, cause_a, alu_op_a, alu_src_a_a, alu_src_b_a};
  assign sel_b = {branch_ne_b, pc_source_b, reg_dst_b, mem_to_reg_b, hilo_sel_b,
                  md_op_b, cause_b, alu_op_b, alu_src_a_b, alu_src_b_b};

  int    checks = 0;
  int    errors = 0;
  string ph = "init";
  exp_t  q_a[$];
  exp_t  q_b[$];
  sel_t  s_f, m_f, m_fl, s_d, m_d, none;

  function automatic sel_t mk(input logic bne, input logic [1:0] pcs,
                              input logic [1:0] rdst, input logic [1:0] m2r,
                              input logic hl, input logic mdop,
                              input logic [1:0] cs, input logic [3:0] aluop,
                              input logic srca, input logic [1:0] srcb);
    return {bne, pcs, rdst, m2r, hl, mdop, cs, aluop, srca, srcb};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit b, input logic [3:0] st, input logic [8:0] we,
                      input sel_t s, input sel_t m);
    exp_t e;
    e = {st, we, s, m};
    if (b) q_b.push_back(e);
    else   q_a.push_back(e);
  endtask

  // Last FETCH cycle plus DECODE of the instance-A instruction just applied
  task automatic push_fd();
    push(1'b0, FETCH, MRD | IRW | PCW, s_f, m_fl);
    push(1'b0, DECODE, 9'h000, s_d, m_d);
  endtask

  task automatic drain(input bit b);
    exp_t e;
    int   n;
    n = 0;
    while ((b ? q_b.size() : q_a.size()) > 0) begin
      @(posedge clk);
      #1;
      e = b ? q_b.pop_front() : q_a.pop_front();
      check($sformatf("%s[%0d].state", ph, n), b ? state_b : state_a, e.st);
      check($sformatf("%s[%0d].we", ph, n), b ? we_b : we_a, e.we);
      if (e.m != '0)
        check($sformatf("%s[%0d].sel", ph, n), (b ? sel_b : sel_a) & e.m, e.s & e.m);
      n++;
    end
  endtask

  initial begin
    s_f  = mk(0, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 4'h0, 0, 2'b01);
    m_f  = mk(0, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 4'hf, 1, 2'b11);
    m_fl = mk(0, 2'b11, 2'b00, 2'b00, 0, 0, 2'b00, 4'hf, 1, 2'b11);
    s_d  = mk(0, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 4'h0, 0, 2'b11);
    m_d  = m_f;
    none = '0;

    reset_a = 1'b0; zero_a = 1'b0; ovf_a = 1'b0; dz_a = 1'b0;
    opcode_a = 6'b000000; funct_a = 6'b100000;
    reset_b = 1'b0; zero_b = 1'b0; ovf_b = 1'b0; dz_b = 1'b0;
    opcode_b = 6'b100011; funct_b = 6'b000000;

    // Reset state
    ph = "reset";
    repeat (2) @(negedge clk);
    check("reset.stateA", state_a, RESET);
    check("reset.outsA", {we_a, sel_a}, 0);
    check("reset.stateB", state_b, RESET);

    // add, no overflow: RESET, FETCH x2, DECODE, EXEC_R, WB_R, FETCH
    ph = "add";
    @(negedge clk);
    reset_a = 1'b1;
    push(0, RESET, 9'h000, none, none);
    push(0, FETCH, MRD, s_f, m_f);
    push_fd();
    push(0, EXEC_R, 9'h000, mk(0,0,0,0,0,0,0,4'h0,1,2'b00), mk(0,0,0,0,0,0,0,4'hf,1,2'b11));
    push(0, WB_R, RGW, mk(0,0,2'b01,0,0,0,0,0,0,0), mk(0,0,2'b11,2'b11,0,0,0,0,0,0));
    push(0, FETCH, MRD, s_f, m_f);
    drain(0);

    // add with overflow held high from FETCH: only the EXEC_R sample counts
    ph = "add_ovf";
    ovf_a = 1'b1;
    push_fd();
    push(0, EXEC_R, 9'h000, none, none);
    push(0, EXC, EXCW, mk(0,0,0,0,0,0,2'b01,0,0,0), mk(0,0,0,0,0,0,2'b11,0,0,0));
    push(0, FETCH, MRD, mk(0,0,0,0,0,0,2'b01,0,0,0), mk(0,0,0,0,0,0,2'b11,0,0,0));
    drain(0);

    // and ignores overflow; cause stays 01
    ph = "and_ovf";
    funct_a = 6'b100100;
    push_fd();
    push(0, EXEC_R, 9'h000, mk(0,0,0,0,0,0,0,4'h2,1,0), mk(0,0,0,0,0,0,0,4'hf,1,0));
    push(0, WB_R, RGW, mk(0,0,2'b01,0,0,0,2'b01,0,0,0), mk(0,0,2'b11,0,0,0,2'b11,0,0,0));
    push(0, FETCH, MRD, s_f, m_f);
    drain(0);
    ovf_a = 1'b0;

    // sub
    ph = "sub";
    funct_a = 6'b100010;
    push_fd();
    push(0, EXEC_R, 9'h000, mk(0,0,0,0,0,0,0,4'h1,1,0), mk(0,0,0,0,0,0,0,4'hf,1,2'b11));
    push(0, WB_R, RGW, none, none);
    push(0, FETCH, MRD, s_f, m_f);
    drain(0);

    // illegal opcode
    ph = "badop";
    opcode_a = 6'b111111;
    push_fd();
    push(0, EXC, EXCW, mk(0,0,0,0,0,0,2'b00,0,0,0), mk(0,0,0,0,0,0,2'b11,0,0,0));
    push(0, FETCH, MRD, s_f, m_f);
    drain(0);

    // div by zero
    ph = "div0";
    opcode_a = 6'b000000; funct_a = 6'b011010; dz_a = 1'b1;
    push_fd();
    push(0, MD_RUN, MDS, mk(0,0,0,0,0,1,0,0,0,0), mk(0,0,0,0,0,1,0,0,0,0));
    push(0, EXC, EXCW, mk(0,0,0,0,0,0,2'b10,0,0,0), mk(0,0,0,0,0,0,2'b11,0,0,0));
    push(0, FETCH, MRD, s_f, m_f);
    drain(0);
    dz_a = 1'b0;

    // div, MD_CYCLES=4
    ph = "div";
    push_fd();
    push(0, MD_RUN, MDS, mk(0,0,0,0,0,1,0,0,0,0), mk(0,0,0,0,0,1,0,0,0,0));
    push(0, MD_RUN, 9'h000, none, none);
    push(0, MD_RUN, 9'h000, none, none);
    push(0, MD_RUN, 9'h000, none, none);
    push(0, FETCH, MRD, s_f, m_f);
    drain(0);

    // mult: md_op low
    ph = "mult";
    funct_a = 6'b011000;
    push_fd();
    push(0, MD_RUN, MDS, mk(0,0,0,0,0,0,0,0,0,0), mk(0,0,0,0,0,1,0,0,0,0));
    repeat (3) push(0, MD_RUN, 9'h000, none, none);
    push(0, FETCH, MRD, s_f, m_f);
    drain(0);

    // mfhi
    ph = "mfhi";
    funct_a = 6'b010000;
    push_fd();
    push(0, MFHL, RGW, mk(0,0,2'b01,2'b11,1,0,0,0,0,0), mk(0,0,2'b11,2'b11,1,0,0,0,0,0));
    push(0, FETCH, MRD, s_f, m_f);
    drain(0);

    // jal
    ph = "jal";
    opcode_a = 6'b000011; funct_a = 6'b000000;
    push_fd();
    push(0, JUMP, PCW | RGW, mk(0,2'b10,2'b10,2'b10,0,0,0,0,0,0),
         mk(0,2'b11,2'b11,2'b11,0,0,0,0,0,0));
    push(0, FETCH, MRD, s_f, m_f);
    drain(0);

    // bne
    ph = "bne";
    opcode_a = 6'b000101;
    push_fd();
    push(0, BRANCH, PCC, mk(1,2'b01,0,0,0,0,0,4'h1,1,2'b00),
         mk(1,2'b11,0,0,0,0,0,4'hf,1,2'b11));
    push(0, FETCH, MRD, s_f, m_f);
    drain(0);

    // lw, then reset while in MEM_RD
    ph = "lw_abort";
    opcode_a = 6'b100011;
    push_fd();
    push(0, MEM_ADDR, 9'h000, mk(0,0,0,0,0,0,0,4'h0,1,2'b10), mk(0,0,0,0,0,0,0,4'hf,1,2'b11));
    push(0, MEM_ADDR, 9'h000, none, none);
    push(0, MEM_RD, MRD, none, none);
    drain(0);
    #2;
    reset_a = 1'b0;
    #1;
    check("abort.state", state_a, RESET);
    check("abort.outs", {we_a, sel_a}, 0);
    @(negedge clk);
    reset_a = 1'b1;
    ph = "abort_rel";
    push(0, RESET, 9'h000, none, none);
    push(0, FETCH, MRD, s_f, m_f);
    drain(0);

    // Instance B: lw with MEM_WAIT=3, 12 cycles from first FETCH to MEM_WB
    ph = "lw_w3";
    @(negedge clk);
    reset_b = 1'b1;
    push(1, RESET, 9'h000, none, none);
    repeat (3) push(1, FETCH, MRD, s_f, m_f);
    push(1, FETCH, MRD | IRW | PCW, s_f, m_fl);
    push(1, DECODE, 9'h000, s_d, m_d);
    push(1, MEM_ADDR, 9'h000, none, none);
    push(1, MEM_ADDR, 9'h000, none, none);
    repeat (4) push(1, MEM_RD, MRD, none, none);
    push(1, MEM_WB, RGW, mk(0,0,0,2'b01,0,0,0,0,0,0), mk(0,0,2'b11,2'b11,0,0,0,0,0,0));
    push(1, FETCH, MRD, s_f, m_f);
    drain(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
# mc_control_fsm

Parametrised multicycle control FSM for the MIPS-subset datapath. It replaces the single-step-per-instruction sequencer with explicit fetch, decode, execute, memory and write-back states, and adds a configurable memory wait counter, a multi-cycle MULT/DIV busy counter, and precise exceptions with an EPC write and a cause code. It sits beside the register file, ALU, HI/LO unit and memory, and drives every mux select and write enable from a registered state.

## Interface
- MEM_WAIT, 1: extra wait cycles per memory access (0..7).
- MD_CYCLES, 32: MULT/DIV busy cycles (1..63).
- CNT_W, 6: counter width; must hold max(MEM_WAIT, MD_CYCLES).
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- opcode  in  6  instruction[31:26], valid from DECODE onward.
- funct  in  6  instruction[5:0].
- zero  in  1  ALU zero flag.
- overflow  in  1  ALU signed overflow, combinational in the current cycle.
- div_zero  in  1  divisor == 0, combinational.
- pc_write, pc_write_cond, branch_ne  out  1 each  PC enable, conditional enable, invert-zero for BNE.
- pc_source  out  2  00 ALU, 01 ALUOut, 10 jump target, 11 register A.
- exc_vec_sel  out  1  PC mux override to the exception vector.
- ir_write, mem_read, mem_write, reg_write, epc_write, md_start, md_op  out  1 each.
- reg_dst  out  2  00 rt, 01 rd, 10 $31.
- mem_to_reg  out  2  00 ALUOut, 01 MDR, 10 PC, 11 HI/LO.
- hilo_sel  out  1  0 LO, 1 HI.
- alu_src_a  out  1  0 PC, 1 A.
- alu_src_b  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 imm<<2.
- alu_op  out  4  0000 ADD, 0001 SUB, 0010 AND, 0011 SLT, 0100 LUI.
- cause  out  2  00 bad opcode, 01 overflow, 10 div-by-zero; held until the next exception.
- state_out  out  4  current state.

## Operation
- States: RESET=0, FETCH=1, DECODE=2, EXEC_R=3, WB_R=4, EXEC_I=5, WB_I=6, MEM_ADDR=7, MEM_RD=8, MEM_WB=9, MEM_WR=10, BRANCH=11, JUMP=12, MD_RUN=13, MFHL=14, EXC=15.
- Moore outputs decoded from state, counter, and the opcode/funct inputs. All outputs are 0 unless listed.
- RESET: the state after reset is released. Goes to FETCH.
- FETCH: mem_read=1, alu_src_a=0, alu_src_b=01, alu_op ADD. Stays MEM_WAIT+1 cycles. In the last cycle, ir_write=1 and pc_write=1 (pc_source 00). Then DECODE.
- DECODE: alu_src_b=11, ADD (branch target into ALUOut). Next state:
  - R-type: add/sub/and/slt go to EXEC_R; mult(011000)/div(011010) go to MD_RUN; mfhi/mflo go to MFHL; jr goes to JUMP.
  - addi/lui go to EXEC_I.
  - lw/sw go to MEM_ADDR.
  - beq/bne go to BRANCH.
  - j/jal go to JUMP.
  - Any other opcode or funct goes to EXC with cause 00.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op from funct. If add/sub and overflow=1, go to EXC with cause 01; otherwise go to WB_R.
- WB_R: reg_dst=01, reg_write=1.
- EXEC_I: src_a=1, src_b=10, ADD (addi) or LUI. addi with overflow goes to EXC with cause 01; otherwise WB_I.
- WB_I: reg_dst=00, reg_write=1.
- MEM_ADDR: src_a=1, src_b=10, ADD. Then MEM_RD (lw) or MEM_WR (sw).
- MEM_RD / MEM_WR: mem_read or mem_write held MEM_WAIT+1 cycles. MEM_RD goes to MEM_WB; MEM_WR goes to FETCH.
- MEM_WB: mem_to_reg=01, reg_write=1.
- BRANCH: src_a=1, src_b=00, SUB, pc_write_cond=1, pc_source=01, branch_ne=1 for bne.
- JUMP: pc_write=1, pc_source=10 (j/jal) or 11 (jr). For jal also reg_write=1, reg_dst=10, mem_to_reg=10.
- MD_RUN:
  - First cycle: md_start=1, md_op=1 for div. If div with div_zero=1, go to EXC with cause 10 and do not count further.
  - Otherwise stay MD_CYCLES cycles, then FETCH.
- MFHL: reg_dst=01, mem_to_reg=11, hilo_sel=1 for mfhi, reg_write=1.
- EXC: epc_write=1, pc_write=1, exc_vec_sel=1. Then FETCH.
- WB_R, WB_I, MEM_WB, BRANCH, JUMP, MFHL and EXC each last 1 cycle and go to FETCH.
- Counter:
  - Clears to 0 on every state change.
  - Increments while the FSM stays in a counted state.
  - Exits when it equals the limit; limit is MEM_WAIT or MD_CYCLES-1.

## Timing
- reset low: state goes to RESET, counter to 0 and cause to 00 immediately, with no clock edge needed. All outputs go to 0 at once.
- Reset asserted mid-instruction aborts with no further writes. The first FETCH follows 2 edges after release.
- Cycles per instruction, with W = MEM_WAIT:
  - R-ALU: W+4.
  - addi/lui: W+4.
  - lw: 2W+6.
  - sw: 2W+5.
  - branch, jump: W+3.
  - mfhi/mflo: W+3.
  - mult/div: W+2+MD_CYCLES.
  - Exception adds 1 cycle after its detecting state.
- Overflow and div_zero are sampled only on the edge leaving EXEC_R/EXEC_I or the first MD_RUN cycle; they are ignored elsewhere.
- No write enable (reg_write, mem_write, pc_write) is asserted in a cycle that also detects an exception.

## Test plan
- Reset low mid-MEM_RD with MEM_WAIT=1 -> state_out=0 and all outputs 0 without a clock edge; after release, the FSM goes RESET then FETCH.
- add, overflow=0, MEM_WAIT=1 -> FETCH 2 cycles, ir_write only in the 2nd. Sequence 1,1,2,3,4,1; one reg_write pulse with reg_dst=01.
- lw with MEM_WAIT=3 -> mem_read high 4 cycles in MEM_RD, then MEM_WB with mem_to_reg=01. Total 12 cycles.
- add with overflow=1 in EXEC_R -> next state 15, cause=01, epc_write=exc_vec_sel=1, no reg_write. Then FETCH.
- div with div_zero=1 -> md_start pulses once, then EXC with cause=10. div with div_zero=0 and MD_CYCLES=4 -> 4 MD_RUN cycles, then FETCH.
- opcode 111111 -> DECODE to EXC with cause=00. jal -> JUMP with pc_source=10, reg_dst=10, mem_to_reg=10, reg_write=1. bne -> branch_ne=1, pc_write_cond=1.
